// File: rtl/car_request_if.sv
// Signal bundle between the roadside car request unit and the traffic light controller.
// The slave modport is the request unit; the master modport is whatever drives the sensors and lights.
interface car_request_if #(
  parameter int CNT_W = 4
) ();

  logic             sensor_raw;
  logic             emergency_raw;
  logic             red;
  logic             yellow;
  logic             green;
  logic             car;
  logic             emergency;
  logic [CNT_W-1:0] queue_count;
  logic             served_pulse;
  logic             overflow;
  logic             light_error;

  modport slave (
    input  sensor_raw, emergency_raw, red, yellow, green,
    output car, emergency, queue_count, served_pulse, overflow, light_error
  );

  modport master (
    output sensor_raw, emergency_raw, red, yellow, green,
    input  car, emergency, queue_count, served_pulse, overflow, light_error
  );

endinterface

// File: rtl/car_request_unit.sv
// Car request unit: debounces the roadside sensor and the emergency input, queues waiting cars,
// raises car towards the controller until the queue is served during green, and checks the lights.
//
//   state   | meaning
//   --------+---------------------------------------------------
//   IDLE    | queue empty, car low
//   REQUEST | cars waiting, car high, waiting for green
//   SERVING | green shown, one car retired per SERVE_CYCLES
module car_request_unit #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SERVE_CYCLES    = 3,
  parameter int CNT_W           = 4
) (
  input logic          clock,
  input logic          reset,
  car_request_if.slave bus
);

  localparam logic [3:0]       DB_LAST  = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       SRV_LAST = 4'(SERVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] Q_MAX    = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVING = 2'd2
  } state_t;

  logic [1:0]       r_sens_sync;
  logic [1:0]       r_emer_sync;
  logic             r_sens_filt;
  logic             r_emer_filt;
  logic [3:0]       r_sens_cnt;
  logic [3:0]       r_emer_cnt;
  logic [CNT_W-1:0] r_queue;
  logic [3:0]       r_timer;
  state_t           r_state;
  logic             r_car;
  logic             r_pulse;
  logic             r_overflow;
  logic             r_light_err;
  logic             r_armed;

  logic w_sens_flip;
  logic w_emer_flip;
  logic w_arrival;
  logic w_green_only;
  logic w_queued;
  logic w_serve;
  logic w_onehot;

  assign w_sens_flip  = (r_sens_sync[1] != r_sens_filt) && (r_sens_cnt == DB_LAST);
  assign w_emer_flip  = (r_emer_sync[1] != r_emer_filt) && (r_emer_cnt == DB_LAST);
  assign w_arrival    = w_sens_flip && !r_sens_filt;
  assign w_green_only = bus.green && !bus.yellow && !bus.red;
  assign w_queued     = (r_queue != '0);
  assign w_serve      = (r_state == SERVING) && w_green_only && w_queued && (r_timer == SRV_LAST);
  assign w_onehot     = ( bus.red && !bus.yellow && !bus.green) ||
                        (!bus.red &&  bus.yellow && !bus.green) ||
                        (!bus.red && !bus.yellow &&  bus.green);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sens_sync <= '0;
      r_emer_sync <= '0;
      r_sens_filt <= 1'b0;
      r_emer_filt <= 1'b0;
      r_sens_cnt  <= '0;
      r_emer_cnt  <= '0;
    end else begin
      r_sens_sync <= {r_sens_sync[0], bus.sensor_raw};
      r_emer_sync <= {r_emer_sync[0], bus.emergency_raw};

      if (r_sens_sync[1] == r_sens_filt) begin
        r_sens_cnt <= '0;
      end else if (w_sens_flip) begin
        r_sens_filt <= !r_sens_filt;
        r_sens_cnt  <= '0;
      end else begin
        r_sens_cnt <= r_sens_cnt + 4'd1;
      end

      if (r_emer_sync[1] == r_emer_filt) begin
        r_emer_cnt <= '0;
      end else if (w_emer_flip) begin
        r_emer_filt <= !r_emer_filt;
        r_emer_cnt  <= '0;
      end else begin
        r_emer_cnt <= r_emer_cnt + 4'd1;
      end
    end
  end

  // A serve and an arrival in the same cycle cancel; a lost arrival at saturation is flagged.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_queue    <= '0;
      r_overflow <= 1'b0;
      r_pulse    <= 1'b0;
    end else begin
      r_pulse <= w_serve;
      if (w_arrival && !w_serve) begin
        if (r_queue == Q_MAX) begin
          r_overflow <= 1'b1;
        end else begin
          r_queue <= r_queue + 1'b1;
        end
      end else if (w_serve && !w_arrival) begin
        r_queue <= r_queue - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_car   <= 1'b0;
      r_timer <= '0;
    end else begin
      if ((r_state != SERVING) || !bus.green) begin
        r_timer <= '0;
      end else if (w_green_only && w_queued) begin
        r_timer <= w_serve ? 4'd0 : r_timer + 4'd1;
      end

      case (r_state)
        IDLE: begin
          if (w_queued) begin
            r_state <= REQUEST;
            r_car   <= 1'b1;
          end
        end
        REQUEST: begin
          if (bus.green) begin
            r_state <= SERVING;
          end
        end
        SERVING: begin
          if (!w_queued) begin
            r_state <= IDLE;
            r_car   <= 1'b0;
          end else if (!bus.green) begin
            r_state <= REQUEST;
          end
        end
        default: begin
          r_state <= IDLE;
          r_car   <= 1'b0;
        end
      endcase
    end
  end

  // The first edge after reset release only arms the light check.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_armed     <= 1'b0;
      r_light_err <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (r_armed && !w_onehot) begin
        r_light_err <= 1'b1;
      end
    end
  end

  assign bus.car          = r_car;
  assign bus.emergency    = r_emer_filt;
  assign bus.queue_count  = r_queue;
  assign bus.served_pulse = r_pulse;
  assign bus.overflow     = r_overflow;
  assign bus.light_error  = r_light_err;

endmodule

// File: tb/tb_car_request_unit.sv
// Testbench for car_request_unit: directed steps plus a randomized phase, all outputs compared
// every cycle against a window-based behavioural model of the request unit.
module tb_car_request_unit;

  localparam int D    = 4;
  localparam int S    = 3;
  localparam int CW   = 2;
  localparam int QMAX = (1 << CW) - 1;

  logic clock;
  logic reset;

  car_request_if #(.CNT_W(CW)) bus ();

  car_request_unit #(
    .DEBOUNCE_CYCLES(D),
    .SERVE_CYCLES   (S),
    .CNT_W          (CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk;
  int n_pass;
  int n_fail;

  // reference model state
  bit hs[$];
  bit he[$];
  bit m_sf, m_ef, m_ovf, m_lerr, m_armed, m_car, m_pulse;
  int m_q, m_tmr, m_st;   // m_st: 0 idle, 1 waiting for green, 2 serving

  // A filtered level flips once the last D synchronised samples all disagree with it.
  // The synchronised sample at an edge is the raw input seen two edges earlier.
  function automatic bit window_flips(input bit h[$], input bit lvl);
    for (int k = 0; k < D; k++) begin
      int j;
      bit v;
      j = h.size() - 3 - k;
      v = (j >= 0) ? h[j] : 1'b0;
      if (v == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clock or negedge reset) begin
    bit arr;
    bit serve;
    bit gonly;
    int nq;
    int nst;
    int ntmr;
    int lights_on;
    if (!reset) begin
      hs.delete();
      he.delete();
      m_sf = 0; m_ef = 0; m_ovf = 0; m_lerr = 0; m_armed = 0; m_car = 0; m_pulse = 0;
      m_q = 0; m_tmr = 0; m_st = 0;
    end else begin
      hs.push_back(bus.sensor_raw);
      he.push_back(bus.emergency_raw);
      if (hs.size() > 16) void'(hs.pop_front());
      if (he.size() > 16) void'(he.pop_front());

      arr = 1'b0;
      if (window_flips(hs, m_sf)) begin
        arr  = !m_sf;
        m_sf = !m_sf;
      end
      if (window_flips(he, m_ef)) m_ef = !m_ef;

      gonly = bus.green && !bus.yellow && !bus.red;
      serve = (m_st == 2) && gonly && (m_q > 0) && (m_tmr == S - 1);

      nq = m_q;
      if (arr && !serve) begin
        if (m_q == QMAX) m_ovf = 1'b1;
        else nq = m_q + 1;
      end else if (serve && !arr) begin
        nq = m_q - 1;
      end

      if (m_st != 2 || !bus.green) ntmr = 0;
      else if (gonly && m_q > 0) ntmr = serve ? 0 : m_tmr + 1;
      else ntmr = m_tmr;

      nst = m_st;
      case (m_st)
        0: if (m_q > 0) nst = 1;
        1: if (bus.green) nst = 2;
        default: begin
          if (m_q == 0) nst = 0;
          else if (!bus.green) nst = 1;
        end
      endcase

      lights_on = int'(bus.red) + int'(bus.yellow) + int'(bus.green);
      if (m_armed && lights_on != 1) m_lerr = 1'b1;
      m_armed = 1'b1;

      m_pulse = serve;
      m_q     = nq;
      m_tmr   = ntmr;
      m_st    = nst;
      m_car   = (nst != 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("car",          32'(bus.car),          32'(m_car));
    chk("emergency",    32'(bus.emergency),    32'(m_ef));
    chk("queue_count",  32'(bus.queue_count),  32'(m_q));
    chk("served_pulse", 32'(bus.served_pulse), 32'(m_pulse));
    chk("overflow",     32'(bus.overflow),     32'(m_ovf));
    chk("light_error",  32'(bus.light_error),  32'(m_lerr));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      check_all();
    end
  endtask

  task automatic lights(input bit r, input bit y, input bit g);
    bus.red    = r;
    bus.yellow = y;
    bus.green  = g;
  endtask

  task automatic arrive();
    bus.sensor_raw = 1'b1;
    step(6);
    bus.sensor_raw = 1'b0;
    step(6);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n_pulse;
    bit  found;
    bit  bounce[5];
    int  s_hold;
    int  e_hold;
    int  l_hold;
    int  k;
    logic [2:0] rnd_l;

    n_chk = 0; n_pass = 0; n_fail = 0;
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    reset = 1'b0;
    bus.sensor_raw    = 1'b0;
    bus.emergency_raw = 1'b0;
    lights(1, 0, 0);
    step(3);
    chk("rst_car",      32'(bus.car),          0);
    chk("rst_queue",    32'(bus.queue_count),  0);
    chk("rst_overflow", 32'(bus.overflow),     0);
    chk("rst_lighterr", 32'(bus.light_error),  0);
    chk("rst_emerg",    32'(bus.emergency),    0);
    chk("rst_pulse",    32'(bus.served_pulse), 0);
    reset = 1'b1;
    step(4);
    chk("idle_lighterr", 32'(bus.light_error), 0);

    // short pulse must be ignored
    bus.sensor_raw = 1'b1;
    step(3);
    bus.sensor_raw = 1'b0;
    step(10);
    chk("glitch_queue", 32'(bus.queue_count), 0);
    chk("glitch_car",   32'(bus.car),         0);

    // arrival latency from the first edge that sees the sensor high
    bus.sensor_raw = 1'b1;
    step(5);
    chk("lat_queue_e5", 32'(bus.queue_count), 0);
    step(1);
    chk("lat_queue_e6", 32'(bus.queue_count), 1);
    chk("lat_car_e6",   32'(bus.car),         0);
    step(1);
    chk("lat_car_e7",   32'(bus.car),         1);
    step(3);
    bus.sensor_raw = 1'b0;
    step(8);

    // two cars served by a long green
    arrive();
    chk("serve_queue_start", 32'(bus.queue_count), 2);
    lights(0, 0, 1);
    n_pulse = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      n_pulse += int'(bus.served_pulse);
    end
    chk("serve_pulses", 32'(n_pulse),          2);
    chk("serve_queue",  32'(bus.queue_count),  0);
    chk("serve_car",    32'(bus.car),          0);
    lights(1, 0, 0);
    step(2);

    // green cut short by yellow
    arrive();
    arrive();
    chk("intr_queue_start", 32'(bus.queue_count), 2);
    lights(0, 0, 1);
    step(2);
    lights(0, 1, 0);
    step(1);
    chk("intr_queue", 32'(bus.queue_count), 2);
    chk("intr_car",   32'(bus.car),         1);
    step(2);
    lights(1, 0, 0);
    step(2);
    lights(0, 0, 1);
    step(3);
    chk("restart_no_early_serve", 32'(bus.queue_count), 2);
    step(1);
    chk("restart_first_serve", 32'(bus.queue_count), 1);
    step(6);
    lights(1, 0, 0);
    step(2);
    chk("restart_queue_empty", 32'(bus.queue_count), 0);

    // saturation
    repeat (4) arrive();
    chk("sat_queue",    32'(bus.queue_count), 3);
    chk("sat_overflow", 32'(bus.overflow),    1);

    // asynchronous reset with a full queue
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_queue",    32'(bus.queue_count), 0);
    chk("async_rst_car",      32'(bus.car),         0);
    chk("async_rst_overflow", 32'(bus.overflow),    0);
    step(2);
    reset = 1'b1;
    step(3);

    // arrival landing on the same edge as a serve
    repeat (3) arrive();
    chk("simul_queue_start", 32'(bus.queue_count), 3);
    lights(0, 0, 1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      if (m_st == 2 && m_tmr == 0) found = 1'b1;
    end
    chk("simul_sync", 32'(found), 1);
    bus.sensor_raw = 1'b1;
    step(5);
    chk("simul_queue_pre", 32'(bus.queue_count), 2);
    step(1);
    chk("simul_queue", 32'(bus.queue_count),  2);
    chk("simul_pulse", 32'(bus.served_pulse), 1);
    bus.sensor_raw = 1'b0;
    step(12);
    lights(1, 0, 0);
    step(3);

    // emergency debounce
    for (int i = 0; i < 5; i++) begin
      bus.emergency_raw = bounce[i];
      step(1);
    end
    chk("emerg_bounce", 32'(bus.emergency), 0);
    bus.emergency_raw = 1'b1;
    step(5);
    chk("emerg_e5", 32'(bus.emergency), 0);
    step(1);
    chk("emerg_e6", 32'(bus.emergency), 1);
    step(3);

    // light check
    chk("light_clean", 32'(bus.light_error), 0);
    lights(1, 0, 1);
    step(1);
    chk("light_err_set", 32'(bus.light_error), 1);
    lights(1, 0, 0);
    step(5);
    chk("light_err_sticky", 32'(bus.light_error), 1);

    // randomized traffic with a reset in the middle
    s_hold = 0; e_hold = 0; l_hold = 0;
    for (int c = 0; c < 400; c++) begin
      if (s_hold == 0) begin
        bus.sensor_raw = 1'($urandom_range(0, 1));
        s_hold = int'($urandom_range(1, 10));
      end
      s_hold--;
      if (e_hold == 0) begin
        bus.emergency_raw = 1'($urandom_range(0, 1));
        e_hold = int'($urandom_range(1, 10));
      end
      e_hold--;
      if (l_hold == 0) begin
        k = int'($urandom_range(0, 29));
        if (k == 0) begin
          rnd_l = 3'($urandom_range(0, 7));
          lights(rnd_l[2], rnd_l[1], rnd_l[0]);
        end else if (k % 3 == 0) lights(1, 0, 0);
        else if (k % 3 == 1) lights(0, 1, 0);
        else lights(0, 0, 1);
        l_hold = int'($urandom_range(1, 12));
      end
      l_hold--;
      if (c == 200) begin
        #2;
        reset = 1'b0;
      end
      if (c == 203) reset = 1'b1;
      step(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
